// File: rtl/scc_mem_pkg.sv
// scc_mem_pkg: shared encodings for the unified memory port arbiter
package scc_mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int DEF_MEM_LATENCY = 1;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant decision with a starvation guard for fetch
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic at_lim;
  // data wins unless fetch has been passed over STARVE_LIMIT times in a row
  always_comb begin
    at_lim = cnt_q == CW'(STARVE_LIMIT);
    gnt_d_o = en_i && d_req_i && !(if_req_i && at_lim);
    gnt_if_o = en_i && if_req_i && !gnt_d_o;
    cnt_d = !en_i ? cnt_q :
            (!if_req_i || gnt_if_o) ? '0 :
            (gnt_d_o && !at_lim) ? cnt_q + CW'(1) : cnt_q;
  end
  // starvation counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data
module mem_port_arbiter
  import scc_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  arb_state_e state_q, state_d;
  logic owner_q, owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [3:0] lat_q, lat_d;
  logic gnt_if, gnt_d;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == ARB_IDLE),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .gnt_if_o (gnt_if),
    .gnt_d_o  (gnt_d)
  );

  // access sequencing: latch the winner, strobe once, count out the read latency
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    lat_d = lat_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ARB_IDLE: if (gnt_d || gnt_if) begin
        state_d = ARB_ISSUE;
        owner_d = gnt_d ? OWN_D : OWN_IF;
        we_d = gnt_d && d_we;
        addr_d = gnt_d ? d_addr : if_addr;
        wdata_d = d_wdata;
      end
      ARB_ISSUE: begin
        state_d = we_q ? ARB_DONE : ARB_WAIT;
        lat_d = 4'(MEM_LATENCY);
      end
      ARB_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = ARB_DONE;
          if_rdata_d = owner_q == OWN_IF ? mem_rdata : if_rdata_q;
          d_rdata_d = owner_q == OWN_D ? mem_rdata : d_rdata_q;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      lat_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      lat_q <= lat_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
  assign if_valid = state_q == ARB_DONE && owner_q == OWN_IF;
  assign d_valid = state_q == ARB_DONE && owner_q == OWN_D;
  assign if_stall = if_req && !if_valid;
  assign d_stall = d_req && !d_valid;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re = state_q == ARB_ISSUE && !we_q;
  assign mem_we = state_q == ARB_ISSUE && we_q;
  assign busy = state_q != ARB_IDLE;
endmodule
